// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/blanking, zero skew to hcnt/vcnt.
// Define VGA_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             clk25m,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_end,
    output logic [15:0]      frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL - 1 >= (1 << CNT_W) || V_TOTAL - 1 >= (1 << CNT_W)) begin : g_width_chk
        $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic             h_wrap;

    // Decode flags from the next counts so the registered flags line up with the counters.
    always_comb begin
        h_wrap     = en && hcnt_q == H_MAX;
        hcnt_d     = en ? (h_wrap ? '0 : hcnt_q + CNT_W'(1)) : hcnt_q;
        vcnt_d     = h_wrap ? (vcnt_q == V_MAX ? '0 : vcnt_q + CNT_W'(1)) : vcnt_q;
        hsync_d    = (hcnt_d >= HS_START && hcnt_d <= HS_END) ? HS_POL : ~HS_POL;
        vsync_d    = (vcnt_d >= VS_START && vcnt_d <= VS_END) ? VS_POL : ~VS_POL;
        video_on_d = hcnt_d < H_ACT && vcnt_d < V_ACT;
    end

    always_ff @(posedge clk25m or posedge rst) begin
        if (rst) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            hsync_q    <= ~HS_POL;
            vsync_q    <= ~VS_POL;
            video_on_q <= 1'b1;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign line_end  = h_wrap;
    assign frame_end = h_wrap && vcnt_q == V_MAX;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb frame_cnt_d = frame_cnt_q + 16'(frame_end);

    always_ff @(posedge clk25m or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-enable bench for vga_timing_gen at default and tiny timings.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       le;
        logic       fe;
    } exp_t;

    logic clk25m = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [9:0] hcnt, vcnt, hcnt_s, vcnt_s;
    logic hsync, vsync, video_on, line_end, frame_end;
    logic hsync_s, vsync_s, video_on_s, line_end_s, frame_end_s;
    logic [15:0] frame_cnt, frame_cnt_s;
    int n = 0;
    int vectors = 0;
    int miscompares = 0;
    bit fc_en;

    vga_timing_gen dut (
        .clk25m(clk25m), .rst(rst), .en(en), .hcnt(hcnt), .vcnt(vcnt),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .line_end(line_end),
        .frame_end(frame_end), .frame_cnt(frame_cnt)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .clk25m(clk25m), .rst(rst), .en(en), .hcnt(hcnt_s), .vcnt(vcnt_s),
        .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s), .line_end(line_end_s),
        .frame_end(frame_end_s), .frame_cnt(frame_cnt_s)
    );

    always #5 clk25m = ~clk25m;

    // Reference position: number of enabled pixels since reset.
    always @(posedge clk25m or posedge rst) begin
        if (rst) n = 0;
        else if (en) n = n + 1;
    end

    function automatic exp_t model(int cnt, int ha, int hf, int hsw, int hb, int va, int vf,
                                   int vsw, int vb, bit hp, bit vp, bit e);
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int p = cnt % (ht * vt);
        int h = p % ht;
        int v = p / ht;
        exp_t r;
        r.h  = 10'(h);
        r.v  = 10'(v);
        r.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        r.vs = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        r.vo = h < ha && v < va;
        r.le = e && h == ht - 1;
        r.fe = r.le && v == vt - 1;
        return r;
    endfunction

    function automatic int exp_frames(int cnt, int frame_len);
        return fc_en ? (cnt / frame_len) % 65536 : 0;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk25m) begin
        exp_t d, s;
        d = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, en);
        s = model(n, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, en);
        chk("hcnt", hcnt, d.h);
        chk("vcnt", vcnt, d.v);
        chk("hsync", hsync, d.hs);
        chk("vsync", vsync, d.vs);
        chk("video_on", video_on, d.vo);
        chk("line_end", line_end, d.le);
        chk("frame_end", frame_end, d.fe);
        chk("frame_cnt", frame_cnt, exp_frames(n, 800 * 525));
        chk("s_hcnt", hcnt_s, s.h);
        chk("s_vcnt", vcnt_s, s.v);
        chk("s_hsync", hsync_s, s.hs);
        chk("s_vsync", vsync_s, s.vs);
        chk("s_video_on", video_on_s, s.vo);
        chk("s_line_end", line_end_s, s.le);
        chk("s_frame_end", frame_end_s, s.fe);
        chk("s_frame_cnt", frame_cnt_s, exp_frames(n, 48));
    end

    task automatic chk_reset_vals();
        chk("rst_hcnt", hcnt, 0);
        chk("rst_vcnt", vcnt, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_video_on", video_on, 1);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_s_hsync", hsync_s, 0);
        chk("rst_s_vsync", vsync_s, 0);
        chk("rst_s_hcnt", hcnt_s, 0);
        chk("rst_s_frame_cnt", frame_cnt_s, 0);
    endtask

    initial begin
`ifdef VGA_FRAME_CNT_EN
        fc_en = 1'b1;
`else
        fc_en = 1'b0;
`endif
        repeat (3) @(posedge clk25m);
        #1 chk_reset_vals();
        rst = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            @(posedge clk25m);
            @(negedge clk25m);
            if (k == 1)   chk("first_step_hcnt", hcnt, 1);
            if (k == 639) chk("lit_vo_639", video_on, 1);
            if (k == 640) chk("lit_vo_640", video_on, 0);
            if (k == 655) chk("lit_hs_655", hsync, 1);
            if (k == 656) chk("lit_hs_656", hsync, 0);
            if (k == 751) chk("lit_hs_751", hsync, 0);
            if (k == 752) chk("lit_hs_752", hsync, 1);
            if (k == 798) chk("lit_le_798", line_end, 0);
            if (k == 799) chk("lit_le_799", line_end, 1);
            if (k == 800) begin
                chk("lit_h_800", hcnt, 0);
                chk("lit_v_800", vcnt, 1);
            end
            if (k == 4)  chk("lit_s_hs_4", hsync_s, 0);
            if (k == 5)  chk("lit_s_hs_5", hsync_s, 1);
            if (k == 6)  chk("lit_s_hs_6", hsync_s, 1);
            if (k == 7)  chk("lit_s_hs_7", hsync_s, 0);
            if (k == 31) chk("lit_s_vs_31", vsync_s, 0);
            if (k == 32) chk("lit_s_vs_32", vsync_s, 1);
            if (k == 40) chk("lit_s_vs_40", vsync_s, 0);
            if (k == 47) begin
                chk("lit_s_fe_47", frame_end_s, 1);
                chk("lit_s_le_47", line_end_s, 1);
            end
            if (k == 48) begin
                chk("lit_s_h_48", hcnt_s, 0);
                chk("lit_s_v_48", vcnt_s, 0);
                chk("lit_s_fc_48", frame_cnt_s, fc_en ? 1 : 0);
            end
        end
        for (int k = 0; k < 1600; k++) begin
            @(posedge clk25m);
            #1 en = ~en;
        end
        chk("lit_toggle_line", vcnt, 2);
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk25m);
            #1 en = $urandom_range(0, 3) != 0;
        end
        @(posedge clk25m);
        #3 rst = 1'b1;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk25m);
        #1 rst = 1'b0;
        en = 1'b1;
        @(posedge clk25m);
        @(negedge clk25m);
        chk("restart_hcnt", hcnt, 1);
        chk("restart_vcnt", vcnt, 0);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk25m);
            #1 en = $urandom_range(0, 4) != 0;
        end
        @(negedge clk25m);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
